// File: rtl/emergency_request_arbiter.sv
// emergency_request_arbiter: syncs/debounces emergency sensors and grants one side at a time with hold, gap and cooldown limits
module emergency_request_arbiter #(
  parameter int DEBOUNCE = 3,
  parameter int HOLD_MIN = 10,
  parameter int HOLD_MAX = 30,
  parameter int GAP_CYC  = 2,
  parameter int COOLDOWN = 20,
  parameter int CW       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic Sensor_Left,
  input  logic Sensor_Right,
  output logic Emergency_Left,
  output logic Emergency_Right,
  output logic Pending_Left,
  output logic Pending_Right,
  output logic Timeout,
  output logic Active
);
  typedef enum logic [1:0] {IDLE, GRANT_L, GRANT_R, GAP} state_t;
  state_t state, next, idle_next;
  logic [1:0] sync_l, sync_r;
  logic [CW-1:0] db_l, db_r, db_l_n, db_r_n, cd_l, cd_r, hold, gap;
  logic qual_l, qual_r, qual_l_n, qual_r_n, el_l, el_r, rr, granted, done, leave;
  always_comb begin
    db_l_n    = (sync_l[1] == qual_l || db_l == CW'(DEBOUNCE - 1)) ? '0 : db_l + 1'b1;
    db_r_n    = (sync_r[1] == qual_r || db_r == CW'(DEBOUNCE - 1)) ? '0 : db_r + 1'b1;
    qual_l_n  = (sync_l[1] != qual_l && db_l == CW'(DEBOUNCE - 1)) ? sync_l[1] : qual_l;
    qual_r_n  = (sync_r[1] != qual_r && db_r == CW'(DEBOUNCE - 1)) ? sync_r[1] : qual_r;
    // a side becomes grantable on the cycle its cooldown drains, giving exactly COOLDOWN low cycles
    el_l      = qual_l && cd_l <= CW'(1);
    el_r      = qual_r && cd_r <= CW'(1);
    idle_next = (el_l && (!el_r || !rr)) ? GRANT_L : el_r ? GRANT_R : IDLE;
    granted   = state == GRANT_L || state == GRANT_R;
    done      = (hold >= CW'(HOLD_MIN) && !(state == GRANT_L ? qual_l : qual_r)) || hold == CW'(HOLD_MAX);
    leave     = granted && done;
    next      = state == IDLE ? idle_next :
                granted ? (done ? GAP : state) :
                (gap == CW'(GAP_CYC) ? idle_next : GAP);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_l <= '0;
      sync_r <= '0;
      db_l <= '0;
      db_r <= '0;
      qual_l <= 1'b0;
      qual_r <= 1'b0;
      cd_l <= '0;
      cd_r <= '0;
      hold <= '0;
      gap <= '0;
      rr <= 1'b0;
      state <= IDLE;
      Emergency_Left <= 1'b0;
      Emergency_Right <= 1'b0;
      Pending_Left <= 1'b0;
      Pending_Right <= 1'b0;
      Timeout <= 1'b0;
      Active <= 1'b0;
    end else begin
      sync_l <= {sync_l[0], Sensor_Left};
      sync_r <= {sync_r[0], Sensor_Right};
      db_l <= db_l_n;
      db_r <= db_r_n;
      qual_l <= qual_l_n;
      qual_r <= qual_r_n;
      cd_l <= (leave && state == GRANT_L) ? CW'(COOLDOWN) : (cd_l != '0 ? cd_l - 1'b1 : '0);
      cd_r <= (leave && state == GRANT_R) ? CW'(COOLDOWN) : (cd_r != '0 ? cd_r - 1'b1 : '0);
      hold <= (next == GRANT_L || next == GRANT_R) ? (state == next ? hold + 1'b1 : CW'(1)) : '0;
      gap <= next == GAP ? (state == GAP ? gap + 1'b1 : CW'(1)) : '0;
      rr <= leave ? state == GRANT_L : rr;
      state <= next;
      Emergency_Left <= next == GRANT_L;
      Emergency_Right <= next == GRANT_R;
      Pending_Left <= qual_l_n && next != GRANT_L;
      Pending_Right <= qual_r_n && next != GRANT_R;
      Timeout <= leave && hold == CW'(HOLD_MAX);
      Active <= next != IDLE;
    end
  end
endmodule
